// File: rtl/fifo_tx_sequencer.sv
// fifo_tx_sequencer: read-side sequencer that pops bytes from the async FIFO
// and hands them to UART TX with an inter-frame gap, busy timeout and frame count.
module fifo_tx_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 16,
    parameter int GAP_CYCLES   = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENABLE,
    input  logic                  ERR_CLR,
    input  logic                  FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
    output logic                  FIFO_R_INC,
    input  logic                  TX_BUSY,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_DATA_VALID,
    output logic                  ACTIVE,
    output logic                  TIMEOUT_ERR,
    output logic [CNT_WIDTH-1:0]  FRAME_CNT
);

    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);
    // A zero-length gap still spends one cycle in GAP
    localparam logic [GW-1:0] GAP_LAST =
        (GAP_CYCLES > 1) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        SEND,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [TW-1:0]         to_cnt_q;
    logic [TW-1:0]         to_cnt_d;
    logic [GW-1:0]         gap_cnt_q;
    logic [GW-1:0]         gap_cnt_d;
    logic                  r_inc_d;
    logic                  valid_d;
    logic [DATA_WIDTH-1:0] tx_data_d;
    logic                  err_d;
    logic [CNT_WIDTH-1:0]  frame_cnt_d;
    logic                  active_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= IDLE;
            to_cnt_q      <= '0;
            gap_cnt_q     <= '0;
            FIFO_R_INC    <= 1'b0;
            TX_DATA_VALID <= 1'b0;
            TX_P_DATA     <= '0;
            TIMEOUT_ERR   <= 1'b0;
            FRAME_CNT     <= '0;
            ACTIVE        <= 1'b0;
        end else begin
            state_q       <= state_d;
            to_cnt_q      <= to_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            FIFO_R_INC    <= r_inc_d;
            TX_DATA_VALID <= valid_d;
            TX_P_DATA     <= tx_data_d;
            TIMEOUT_ERR   <= err_d;
            FRAME_CNT     <= frame_cnt_d;
            ACTIVE        <= active_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        to_cnt_d    = to_cnt_q;
        gap_cnt_d   = '0;
        r_inc_d     = 1'b0;
        valid_d     = 1'b0;
        tx_data_d   = TX_P_DATA;
        // A timeout raised below overrides a same-cycle clear
        err_d       = TIMEOUT_ERR & ~ERR_CLR;
        frame_cnt_d = FRAME_CNT;

        unique case (state_q)
            IDLE: begin
                if (ENABLE && !FIFO_EMPTY) begin
                    tx_data_d = FIFO_RD_DATA;
                    r_inc_d   = 1'b1;
                    state_d   = POP;
                end
            end
            POP: begin
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                to_cnt_d = '0;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (TX_BUSY) begin
                    state_d = WAIT_DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = GAP;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!TX_BUSY) begin
                    frame_cnt_d = FRAME_CNT + 1'b1;
                    state_d     = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q >= GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        active_d = (state_d != IDLE);
    end

endmodule

// File: doc/fifo_tx_sequencer.md
Name: fifo_tx_sequencer

Overview:
Read-side sequencer between the async FIFO's read port and the UART TX. It runs in the FIFO read-clock domain and pops one byte whenever the FIFO is non-empty and sequencing is enabled. It hands the byte to UART TX with a one-cycle valid strobe, then tracks TX_BUSY through the frame. It enforces an inter-frame gap, detects a TX that never starts (timeout), and counts completed frames.

Parameters:
DATA_WIDTH, 8, width of FIFO/TX data.
BUSY_TIMEOUT, 16, cycles allowed in WAIT_BUSY for TX_BUSY to rise (≥2).
GAP_CYCLES, 2, idle cycles inserted after each frame (0 = no gap).
CNT_WIDTH, 16, width of frame counter.

Ports:
CLK  in  1  clock, same as FIFO read clock.
RST  in  1  asynchronous, active-low reset.
ENABLE  in  1  level; 1 allows new pops.
ERR_CLR  in  1  one-cycle pulse; clears TIMEOUT_ERR.
FIFO_EMPTY  in  1  FIFO empty flag (read domain).
FIFO_RD_DATA  in  DATA_WIDTH  FIFO read data; combinational from current read address.
FIFO_R_INC  out  1  one-cycle pop strobe to FIFO.
TX_BUSY  in  1  UART TX busy.
TX_P_DATA  out  DATA_WIDTH  registered byte to TX.
TX_DATA_VALID  out  1  one-cycle load strobe to TX.
ACTIVE  out  1  1 in any state other than IDLE.
TIMEOUT_ERR  out  1  sticky busy-timeout flag.
FRAME_CNT  out  CNT_WIDTH  completed-frame count, wraps.

Behaviour:
- Reset (RST=0, async): state=IDLE. All outputs 0: FIFO_R_INC, TX_P_DATA, TX_DATA_VALID, ACTIVE, TIMEOUT_ERR, FRAME_CNT. Internal counters 0.
- All outputs are registered.
- FSM states: IDLE, POP, SEND, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - If ENABLE && !FIFO_EMPTY: TX_P_DATA<=FIFO_RD_DATA, FIFO_R_INC<=1, go to POP.
  - Otherwise stay; no strobes.
- POP:
  - FIFO_R_INC drops to 0; TX_DATA_VALID<=1; go to SEND.
  - Net effect: exactly one pop per byte, and the valid strobe is one cycle after the pop strobe.
- SEND: TX_DATA_VALID<=0, timeout counter<=0, go to WAIT_BUSY.
- WAIT_BUSY:
  - TX_BUSY=1: go to WAIT_DONE.
  - Else counter++. When counter==BUSY_TIMEOUT-1 with TX_BUSY still 0: TIMEOUT_ERR<=1, byte dropped (no retry, FRAME_CNT unchanged), go to GAP.
- WAIT_DONE: on TX_BUSY=0, FRAME_CNT<=FRAME_CNT+1 (mod 2^CNT_WIDTH), go to GAP.
- GAP:
  - Counts GAP_CYCLES cycles, then goes to IDLE.
  - GAP_CYCLES=0: GAP lasts exactly one cycle.
- Timing:
  - Minimum pop-to-pop spacing: 5 cycles + TX frame + GAP_CYCLES.
  - The FIFO_EMPTY update latency after a pop (≤2 cycles) is covered by this spacing, so no double-pop of the last entry.
- ENABLE deasserted mid-frame: the current frame completes normally and the block then stays in IDLE. ENABLE is only sampled in IDLE.
- TIMEOUT_ERR: sticky until ERR_CLR. If ERR_CLR and a new timeout occur in the same cycle, set wins.
- ACTIVE=0 only in IDLE. ACTIVE is the registered image of next-state≠IDLE, so it is asserted in the same cycle FIFO_R_INC first goes high.
- FIFO_EMPTY rising while in POP..GAP has no effect on the byte already captured.
- Async reset mid-frame: immediate return to reset values. Any byte already popped is lost, and the bench must not expect it.

Test Plan:
- Reset: hold RST=0 with FIFO_EMPTY=0, ENABLE=1 → all outputs 0; no FIFO_R_INC during reset or in the first cycle after release.
- Single byte: FIFO holds 0xA5, ENABLE=1, TX_BUSY rises 2 cycles after TX_DATA_VALID and stays high 10 cycles.
  - Expect exactly one FIFO_R_INC pulse, then TX_DATA_VALID one cycle later with TX_P_DATA=0xA5.
  - FRAME_CNT becomes 1; ACTIVE returns to 0 after GAP_CYCLES=2 gap cycles.
- Burst: FIFO holds 0x01,0x02,0x03 → three pops in order, three TX frames each separated by ≥2 gap cycles, FRAME_CNT=3, and FIFO_R_INC never asserted while FIFO_EMPTY=1.
- Timeout: TX_BUSY tied 0, one byte 0x5A → TIMEOUT_ERR=1 after 16 WAIT_BUSY cycles, FRAME_CNT unchanged, block returns to IDLE.
  - ERR_CLR pulse then clears TIMEOUT_ERR; a simultaneous ERR_CLR and new timeout leaves it at 1.
- Enable drop: deassert ENABLE one cycle after TX_DATA_VALID with 2 bytes queued → first frame completes, no second pop while ENABLE=0.
  - Re-enable → second byte is sent.
- Wrap: set CNT_WIDTH=4, send 17 frames → FRAME_CNT=1.
